// File: rtl/password_sequence_sender_if.sv
// Digit bus between the sequence sender (master) and the serial password lock (slave).
// The lock returns its status lights on the same bundle.
interface password_sequence_sender_if;
    logic [3:0] digit;
    logic       setMode;
    logic       digitValid;
    logic       unlockLight;
    logic       errorLight;
    logic       warningLight;

    modport master (
        output digit,
        output setMode,
        output digitValid,
        input  unlockLight,
        input  errorLight,
        input  warningLight
    );

    modport slave (
        input  digit,
        input  setMode,
        input  digitValid,
        output unlockLight,
        output errorLight,
        output warningLight
    );
endinterface

// File: rtl/password_sequence_sender.sv
// Serial password lock initiator: sends a verify/set/admin digit sequence, then
// classifies the lock's response lights into a one-cycle done pulse with a result code.
module password_sequence_sender #(
    parameter int DIGITS  = 4,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [1:0]            cmd,
    input  logic [4*DIGITS-1:0]   code,
    password_sequence_sender_if.master lock,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            result,
    output logic [2:0]            dbgState
);

    localparam int IDXW  = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;
    localparam int GAPW  = (GAP     > 1) ? $clog2(GAP)     : 1;
    localparam int WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] CMD_VERIFY = 2'b00;
    localparam logic [1:0] CMD_SET    = 2'b01;
    localparam logic [1:0] CMD_ADMIN  = 2'b10;

    localparam logic [1:0] RES_OK      = 2'b00;
    localparam logic [1:0] RES_ERROR   = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;
    localparam logic [1:0] RES_LOCKED  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_GAP  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              stateReg, stateNext;
    logic [IDXW-1:0]     idxReg, idxNext;
    logic [GAPW-1:0]     gapReg, gapNext;
    logic [WAITW-1:0]    waitReg, waitNext;
    logic [1:0]          cmdReg, cmdNext;
    logic [4*DIGITS-1:0] codeReg, codeNext;
    logic [1:0]          doneCode;

    logic [3:0]          digitReg, digitNext;
    logic                setModeReg, setModeNext;
    logic                validReg, validNext;
    logic                doneReg, doneNext;
    logic [1:0]          resultReg, resultNext;

    logic [1:0]          cmdEff;
    logic                abortReq;
    logic                lastDigit;
    logic                waitHit;
    logic [1:0]          waitCode;

    // Admin sequence is fixed at 0,1,2,9; any digits beyond the fourth are sent as 0.
    logic [4*DIGITS-1:0] adminCode;
    logic [3:0]          nibbleNext [DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
            localparam logic [3:0] ADM = (gi == 0) ? 4'd0 :
                                         (gi == 1) ? 4'd1 :
                                         (gi == 2) ? 4'd2 :
                                         (gi == 3) ? 4'd9 : 4'd0;
            assign adminCode[4*(DIGITS-1-gi) +: 4] = ADM;
            assign nibbleNext[gi] = codeNext[4*(DIGITS-1-gi) +: 4];
        end
    endgenerate

    assign cmdEff    = (cmd == 2'b11) ? CMD_VERIFY : cmd;
    assign abortReq  = lock.warningLight && (cmdReg != CMD_ADMIN);
    assign lastDigit = (idxReg == IDXW'(DIGITS - 1));

    // Response classification for the wait phase; waitHit means a qualifying event this cycle.
    always_comb begin
        waitHit  = 1'b0;
        waitCode = RES_OK;
        case (cmdReg)
            CMD_SET: begin
                waitHit  = 1'b1;
                waitCode = RES_OK;
            end
            CMD_ADMIN: begin
                if (!lock.warningLight) begin
                    waitHit  = 1'b1;
                    waitCode = RES_OK;
                end
            end
            default: begin
                if (lock.errorLight) begin
                    waitHit  = 1'b1;
                    waitCode = RES_ERROR;
                end else if (lock.unlockLight) begin
                    waitHit  = 1'b1;
                    waitCode = RES_OK;
                end else if (lock.warningLight) begin
                    waitHit  = 1'b1;
                    waitCode = RES_LOCKED;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateReg   <= S_IDLE;
            idxReg     <= '0;
            gapReg     <= '0;
            waitReg    <= '0;
            cmdReg     <= CMD_VERIFY;
            codeReg    <= '0;
            digitReg   <= 4'hF;
            setModeReg <= 1'b0;
            validReg   <= 1'b0;
            doneReg    <= 1'b0;
            resultReg  <= RES_OK;
        end else begin
            stateReg   <= stateNext;
            idxReg     <= idxNext;
            gapReg     <= gapNext;
            waitReg    <= waitNext;
            cmdReg     <= cmdNext;
            codeReg    <= codeNext;
            digitReg   <= digitNext;
            setModeReg <= setModeNext;
            validReg   <= validNext;
            doneReg    <= doneNext;
            resultReg  <= resultNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        idxNext   = idxReg;
        gapNext   = gapReg;
        waitNext  = waitReg;
        cmdNext   = cmdReg;
        codeNext  = codeReg;
        doneCode  = RES_OK;
        case (stateReg)
            S_IDLE: begin
                if (start) begin
                    cmdNext  = cmdEff;
                    codeNext = (cmdEff == CMD_ADMIN) ? adminCode : code;
                    idxNext  = '0;
                    if (lock.warningLight && (cmdEff != CMD_ADMIN)) begin
                        stateNext = S_DONE;
                        doneCode  = RES_LOCKED;
                    end else begin
                        stateNext = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (abortReq) begin
                    stateNext = S_DONE;
                    doneCode  = RES_LOCKED;
                end else if (lastDigit) begin
                    stateNext = S_WAIT;
                    waitNext  = '0;
                end else begin
                    idxNext = idxReg + IDXW'(1);
                    // Admin digits must land on consecutive cycles, so they never get gaps.
                    if ((GAP > 0) && (cmdReg != CMD_ADMIN)) begin
                        stateNext = S_GAP;
                        gapNext   = '0;
                    end
                end
            end
            S_GAP: begin
                if (abortReq) begin
                    stateNext = S_DONE;
                    doneCode  = RES_LOCKED;
                end else if (gapReg == GAPW'(GAP - 1)) begin
                    stateNext = S_SEND;
                end else begin
                    gapNext = gapReg + GAPW'(1);
                end
            end
            S_WAIT: begin
                if (waitHit) begin
                    stateNext = S_DONE;
                    doneCode  = waitCode;
                end else if (waitReg == WAITW'(TIMEOUT - 1)) begin
                    stateNext = S_DONE;
                    doneCode  = RES_TIMEOUT;
                end else begin
                    waitNext = waitReg + WAITW'(1);
                end
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so registered outputs line up with the state.
    always_comb begin
        digitNext   = 4'hF;
        validNext   = 1'b0;
        setModeNext = 1'b0;
        doneNext    = 1'b0;
        resultNext  = resultReg;
        case (stateNext)
            S_SEND: begin
                digitNext   = nibbleNext[idxNext];
                validNext   = 1'b1;
                setModeNext = (cmdNext == CMD_SET);
            end
            S_GAP, S_WAIT: begin
                setModeNext = (cmdNext == CMD_SET);
            end
            S_DONE: begin
                doneNext   = 1'b1;
                resultNext = doneCode;
            end
            default: begin
            end
        endcase
    end

    assign lock.digit      = digitReg;
    assign lock.setMode    = setModeReg;
    assign lock.digitValid = validReg;
    assign busy            = (stateReg != S_IDLE);
    assign done            = doneReg;
    assign result          = resultReg;
    assign dbgState        = stateReg;

endmodule

// File: tb/tb_password_sequence_sender.sv
// Directed bench for password_sequence_sender: one DUT with GAP=1 and one with GAP=0,
// a small behavioural lock driving the status lights, and hand-computed expectations.
module tb_password_sequence_sender;

    localparam int DIGITS = 4;

    localparam int R_NONE    = 0;
    localparam int R_UNLOCK  = 1;
    localparam int R_BOTH    = 2;
    localparam int R_CLRWARN = 3;
    localparam int R_WARN2   = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start0, start1;
    logic [1:0]  cmd;
    logic [15:0] code;
    logic        unlockLight, errorLight, warningLight;

    logic        busy0, busy1, done0, done1;
    logic [1:0]  result0, result1;
    logic [2:0]  dbg0, dbg1;

    always #5 CLK = ~CLK;

    password_sequence_sender_if lockIf0 ();
    password_sequence_sender_if lockIf1 ();

    assign lockIf0.unlockLight  = unlockLight;
    assign lockIf0.errorLight   = errorLight;
    assign lockIf0.warningLight = warningLight;
    assign lockIf1.unlockLight  = unlockLight;
    assign lockIf1.errorLight   = errorLight;
    assign lockIf1.warningLight = warningLight;

    password_sequence_sender #(.DIGITS(DIGITS), .GAP(1), .TIMEOUT(8)) dut0 (
        .CLK(CLK), .RST(RST), .start(start0), .cmd(cmd), .code(code),
        .lock(lockIf0.master), .busy(busy0), .done(done0), .result(result0), .dbgState(dbg0)
    );

    password_sequence_sender #(.DIGITS(DIGITS), .GAP(0), .TIMEOUT(8)) dut1 (
        .CLK(CLK), .RST(RST), .start(start1), .cmd(cmd), .code(code),
        .lock(lockIf1.master), .busy(busy1), .done(done1), .result(result1), .dbgState(dbg1)
    );

    int          sel;
    logic [3:0]  mDigit;
    logic        mValid, mSetMode, mBusy, mDone;
    logic [1:0]  mResult;
    logic [2:0]  mDbg;

    always_comb begin
        if (sel == 0) begin
            mDigit = lockIf0.digit; mValid = lockIf0.digitValid; mSetMode = lockIf0.setMode;
            mBusy = busy0; mDone = done0; mResult = result0; mDbg = dbg0;
        end else begin
            mDigit = lockIf1.digit; mValid = lockIf1.digitValid; mSetMode = lockIf1.setMode;
            mBusy = busy1; mDone = done1; mResult = result1; mDbg = dbg1;
        end
    end

    int vecCount  = 0;
    int missCount = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    int          tBusy, tValid, tSetMode;
    logic [63:0] tTrace;
    logic [1:0]  tResult;

    // Runs one transaction, recording every busy-cycle digit as a nibble trace, and
    // plays the lock side according to kind/dly relative to the last digit.
    task automatic runTxn(input string name, input int s, input logic [1:0] c,
                          input logic [15:0] cd, input int kind, input int dly,
                          input int restartAt);
        int sinceLast;
        bit got;
        sel = s; tBusy = 0; tValid = 0; tSetMode = 0; tTrace = '0; tResult = 2'b00;
        got = 1'b0; sinceLast = -1;
        @(negedge CLK);
        cmd = c; code = cd;
        if (s == 0) start0 = 1'b1; else start1 = 1'b1;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(negedge CLK);
            start0 = 1'b0; start1 = 1'b0;
            if (cyc == restartAt) begin
                cmd = 2'b01; code = 16'hABCD;
                if (s == 0) start0 = 1'b1; else start1 = 1'b1;
            end
            if (mBusy) begin
                tBusy++;
                tTrace = (tTrace << 4) | 64'(mDigit);
            end
            if (mSetMode) tSetMode++;
            if (mValid) tValid++;
            if (mValid && tValid == DIGITS) sinceLast = 0;
            else if (sinceLast >= 0) sinceLast++;
            if (mDone) begin
                got = 1'b1;
                tResult = mResult;
            end
            case (kind)
                R_UNLOCK:  if (sinceLast == dly) unlockLight = 1'b1;
                R_BOTH:    if (sinceLast == dly) begin unlockLight = 1'b1; errorLight = 1'b1; end
                R_CLRWARN: if (sinceLast == dly) warningLight = 1'b0;
                R_WARN2:   if (tValid == 2) warningLight = 1'b1;
                default: ;
            endcase
        end
        start0 = 1'b0; start1 = 1'b0;
        checkVal({name, ".doneSeen"}, 64'(got), 64'd1);
        if (got) begin
            @(negedge CLK);
            checkVal({name, ".donePulse"}, 64'(mDone), 64'd0);
            checkVal({name, ".idleAfter"}, 64'(mBusy), 64'd0);
            checkVal({name, ".setModeAfter"}, 64'(mSetMode), 64'd0);
        end
        unlockLight = 1'b0; errorLight = 1'b0; warningLight = 1'b0;
        $display("txn %s: cmd=%b busy=%0d valid=%0d setMode=%0d trace=%0h result=%b",
                 name, c, tBusy, tValid, tSetMode, tTrace, tResult);
    endtask

    initial begin
        int doneCnt;
        RST = 1'b0; start0 = 1'b0; start1 = 1'b0; cmd = 2'b00; code = '0;
        unlockLight = 1'b0; errorLight = 1'b0; warningLight = 1'b0; sel = 0;

        repeat (2) @(negedge CLK);
        #1;
        checkVal("rst.digit",   64'(mDigit),   64'hF);
        checkVal("rst.valid",   64'(mValid),   64'd0);
        checkVal("rst.setMode", 64'(mSetMode), 64'd0);
        checkVal("rst.busy",    64'(mBusy),    64'd0);
        checkVal("rst.done",    64'(mDone),    64'd0);
        checkVal("rst.result",  64'(mResult),  64'd0);
        checkVal("rst.state",   64'(mDbg),     64'd0);
        @(negedge CLK);
        RST = 1'b1;

        runTxn("verify1234", 0, 2'b00, 16'h1234, R_UNLOCK, 2, -1);
        checkVal("verify1234.trace",   tTrace,          64'h1F2F3F4FFF);
        checkVal("verify1234.valid",   64'(tValid),     64'd4);
        checkVal("verify1234.setMode", 64'(tSetMode),   64'd0);
        checkVal("verify1234.busy",    64'(tBusy),      64'd10);
        checkVal("verify1234.result",  64'(tResult),    64'd0);

        runTxn("set5678", 1, 2'b01, 16'h5678, R_NONE, 0, -1);
        checkVal("set5678.trace",   tTrace,        64'h5678FF);
        checkVal("set5678.valid",   64'(tValid),   64'd4);
        checkVal("set5678.setMode", 64'(tSetMode), 64'd5);
        checkVal("set5678.busy",    64'(tBusy),    64'd6);
        checkVal("set5678.result",  64'(tResult),  64'd0);

        runTxn("verifyBad", 0, 2'b00, 16'h9999, R_BOTH, 1, -1);
        checkVal("verifyBad.trace",  tTrace,       64'h9F9F9F9FF);
        checkVal("verifyBad.busy",   64'(tBusy),   64'd9);
        checkVal("verifyBad.result", 64'(tResult), 64'd1);
        sel = 0;
        repeat (3) @(negedge CLK);
        checkVal("verifyBad.resultHeld", 64'(mResult), 64'd1);

        warningLight = 1'b1;
        runTxn("admin", 0, 2'b10, 16'hFFFF, R_CLRWARN, 3, -1);
        checkVal("admin.trace",  tTrace,       64'h0129FFFF);
        checkVal("admin.valid",  64'(tValid),  64'd4);
        checkVal("admin.busy",   64'(tBusy),   64'd8);
        checkVal("admin.result", 64'(tResult), 64'd0);

        warningLight = 1'b1;
        runTxn("adminTimeout", 0, 2'b10, 16'h0000, R_NONE, 0, -1);
        checkVal("adminTimeout.trace",  tTrace,       64'h0129FFFFFFFFF);
        checkVal("adminTimeout.busy",   64'(tBusy),   64'd13);
        checkVal("adminTimeout.result", 64'(tResult), 64'd2);

        warningLight = 1'b1;
        runTxn("verifyLocked", 0, 2'b00, 16'h1234, R_NONE, 0, -1);
        checkVal("verifyLocked.valid",  64'(tValid),  64'd0);
        checkVal("verifyLocked.busy",   64'(tBusy),   64'd1);
        checkVal("verifyLocked.result", 64'(tResult), 64'd3);

        runTxn("verifyAbort", 0, 2'b00, 16'h1234, R_WARN2, 0, -1);
        checkVal("verifyAbort.trace",  tTrace,       64'h1F2F);
        checkVal("verifyAbort.valid",  64'(tValid),  64'd2);
        checkVal("verifyAbort.busy",   64'(tBusy),   64'd4);
        checkVal("verifyAbort.result", 64'(tResult), 64'd3);

        // Reset dropped while a set transaction sits in its gap slot.
        sel = 0;
        @(negedge CLK);
        cmd = 2'b01; code = 16'h1234; start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        @(negedge CLK);
        checkVal("rstGap.stateBefore",   64'(mDbg),     64'd2);
        checkVal("rstGap.setModeBefore", 64'(mSetMode), 64'd1);
        #2 RST = 1'b0;
        #1;
        checkVal("rstGap.digit",   64'(mDigit),   64'hF);
        checkVal("rstGap.busy",    64'(mBusy),    64'd0);
        checkVal("rstGap.setMode", 64'(mSetMode), 64'd0);
        checkVal("rstGap.valid",   64'(mValid),   64'd0);
        checkVal("rstGap.result",  64'(mResult),  64'd0);
        @(negedge CLK);
        RST = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (mDone) doneCnt++;
        end
        checkVal("rstGap.noDone", 64'(doneCnt), 64'd0);
        $display("txn rstGap: reset in gap, done pulses after=%0d", doneCnt);

        runTxn("busyStart", 0, 2'b00, 16'h1234, R_UNLOCK, 2, 3);
        checkVal("busyStart.trace",   tTrace,        64'h1F2F3F4FFF);
        checkVal("busyStart.setMode", 64'(tSetMode), 64'd0);
        checkVal("busyStart.busy",    64'(tBusy),    64'd10);
        checkVal("busyStart.result",  64'(tResult),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
